// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute and a word-addressed data memory with async read / sync write.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module lsu_mem_ctrl #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        fault_q;

    logic        accept;
    logic        misalign;
    logic        fault_now;

    // Lane select plus sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or halfword lane of the old word; other bytes survive.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        r = old;
        if (size == SIZE_BYTE) begin
            case (lane)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (lane[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    always_comb begin
        misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`endif
        fault_now = (req_size == SIZE_ILL) ||
                    (req_addr[31:2] >= 30'(DEPTH_WORDS)) ||
                    misalign;
    end

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (fault_now) begin
                        state_next = RESP;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                state_next = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_we     = 1'b1;
                mem_wdata  = (size_q == SIZE_WORD) ? wdata_q
                                                   : store_merge(merge_q, wdata_q, size_q, addr_q[1:0]);
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch at accept; load data and merge word captured in READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            fault_q    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                fault_q    <= fault_now;
                resp_rdata <= '0;
            end
            if (state == READ) begin
                merge_q <= mem_rdata;
                if (!we_q) begin
                    resp_rdata <= load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
                end
            end
        end
    end

    assign resp_fault = fault_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed test-plan steps then random requests
// compared against a byte-array memory model.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl #(.DEPTH_WORDS(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: async read, sync write; preloaded from init_words while mem_load is high.
    logic [31:0] tbmem [0:63];
    logic [31:0] init_words [0:63];
    logic        mem_load;
    int          we_cnt;

    assign mem_rdata = tbmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) tbmem[i] <= init_words[i];
        end else if (mem_we) begin
            tbmem[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    // Reference model: plain byte-addressed memory image.
    logic [7:0] ref_mem [0:255];
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] size, input logic uns);
        logic [7:0]  v8;
        logic [15:0] v16;
        int          b;
        if (size == 2'd0) begin
            v8 = ref_mem[a];
            return uns ? {24'h0, v8} : {{24{v8[7]}}, v8};
        end else if (size == 2'd1) begin
            b = a - (a % 2);
            v16 = {ref_mem[b+1], ref_mem[b]};
            return uns ? {16'h0, v16} : {{16{v16[15]}}, v16};
        end
        return ref_word(a / 4);
    endfunction

    task automatic ref_store(input int a, input logic [1:0] size, input logic [31:0] wd);
        int b;
        if (size == 2'd0) begin
            ref_mem[a] = wd[7:0];
        end else if (size == 2'd1) begin
            b = a - (a % 2);
            ref_mem[b]   = wd[7:0];
            ref_mem[b+1] = wd[15:8];
        end else begin
            b = a - (a % 4);
            for (int k = 0; k < 4; k++) ref_mem[b+k] = wd[8*k +: 8];
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd_obs);
        logic        exp_fault;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;
        int          lat;
        int          we0;
        exp_fault = (size == 2'd3) || ((addr >> 2) >= 32'd64);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) exp_fault = 1'b1;
`endif
        exp_rd = '0;
        exp_word = '0;
        exp_we = 0;
        if (exp_fault) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            exp_rd = ref_load(int'(addr), size, uns);
        end else begin
            exp_lat = (size == 2'd2) ? 2 : 3;
            exp_we = 1;
            ref_store(int'(addr), size, wd);
            exp_word = ref_word(int'(addr >> 2));
        end

        @(negedge clk);
        req_we = we;
        req_size = size;
        req_unsigned = uns;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        we0 = we_cnt;
        lat = 0;
        rd_obs = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) begin
                check({tag, "_wdata"}, mem_wdata, exp_word);
                check({tag, "_waddr"}, mem_addr, {addr[31:2], 2'b00});
            end
            if (resp_valid) begin
                lat = c;
                rd_obs = resp_rdata;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_wecount"}, we_cnt - we0, exp_we);
        @(negedge clk);
        check({tag, "_onepulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_readyback"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        logic [31:0] ra;
        int          we0;
        checks = 0;
        errors = 0;
        we_cnt = 0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            init_words[i] = w;
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
        end
        mem_load = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        mem_load = 1'b0;
        @(negedge clk);

        do_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        do_req("lb_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd);
        check("lb_13_const", rd, 32'hFFFFFFDE);
        do_req("lbu_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd);
        check("lbu_13_const", rd, 32'h000000DE);
        do_req("sb_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, rd);
        do_req("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
        check("lw_10_const", rd, 32'hDEAD55EF);
        do_req("sh_12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h12348001, rd);
        do_req("lh_12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
        check("lh_12_const", rd, 32'hFFFF8001);
        do_req("lhu_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);
        check("lhu_12_const", rd, 32'h00008001);
        do_req("lhu_10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd);
        check("lhu_10_const", rd, 32'h000055EF);
        do_req("lw_06", 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, rd);
        do_req("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd);
        do_req("ill_ld", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, rd);
        do_req("ill_st", 1'b1, 2'd3, 1'b0, 32'h24, 32'hFFFFFFFF, rd);
        do_req("sb_oor", 1'b1, 2'd0, 1'b0, 32'h1FC, 32'h77, rd);

        // Reset landing in READ of a sub-word store drops it entirely.
        @(negedge clk);
        req_we = 1'b1;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'h21;
        req_wdata = 32'h000000C3;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        we0 = we_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_ready", {31'b0, req_ready}, 32'd1);
        check("rstmid_resp0", {31'b0, resp_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rstmid_resp", {31'b0, resp_valid}, 32'd0);
        end
        check("rstmid_nowrite", we_cnt - we0, 32'd0);
        do_req("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);

        for (int n = 0; n < 80; n++) begin
            ra = $urandom_range(0, 32'h10F);
            if ($urandom_range(0, 15) == 0) ra = $urandom;
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom, rd);
        end
        for (int i = 0; i < 64; i++) begin
            check($sformatf("final_mem%0d", i), tbmem[i], ref_word(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the execute stage and the 32-bit word-addressed data memory, which has an asynchronous read and a synchronous single-cycle write. It accepts one load or store request at a time over a valid/ready handshake, performs byte and halfword alignment and sign/zero extension on loads, and read-modify-write merging on sub-word stores. It returns one registered response per request and flags misaligned, illegal-size and out-of-range accesses without touching memory.

## Interface
- DEPTH_WORDS, 64, number of 32-bit words in the attached data memory; word index ≥ DEPTH_WORDS is out of range
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request rejected; valid with resp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned byte address, {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  asynchronous read data for mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. Handshake is req_valid && req_ready; all req_* are latched on that edge.
- Fault check at accept: size=11, word index addr[31:2] ≥ DEPTH_WORDS, or misalignment (see Configuration). A faulting request goes IDLE→RESP with resp_fault=1, never asserts mem_we, and returns resp_rdata=0.
- Load: IDLE→READ→RESP. In READ, mem_addr is driven. Lane is selected at the clock edge: byte = word[8*addr[1:0] +: 8], half = word[16*addr[1] +: 16]. The value is extended per req_unsigned and registered into resp_rdata.
- Word store: IDLE→WRITE→RESP. In WRITE, mem_we=1 and mem_wdata=req_wdata.
- Sub-word store: IDLE→READ→WRITE→RESP. READ captures mem_rdata into a merge register. WRITE drives the merged word: the byte lane addr[1:0] is replaced by wdata[7:0], or the half lane addr[1] by wdata[15:0]. Other bytes are preserved.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- mem_we is high only in WRITE, for exactly one cycle per store. mem_addr holds the latched word address from accept until the next accept.

## Timing
- Accept at edge T. Response cycle: fault T+1; load T+2; word store T+2; sub-word store T+3. Next accept is possible at the edge ending the RESP cycle +1 (ready rises in the cycle after RESP).
- Store data is visible in memory in the cycle after WRITE.
- Reset values: state IDLE, req_ready=1 (IDLE), resp_valid=0, resp_fault=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, merge register 0.
- Reset in any state returns the controller to IDLE at that edge. The in-flight request is dropped, with no response and no subsequent mem_we.
- req_valid while not ready is ignored. The requester must hold the request until the handshake.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 faults.
- Undefined: misalignment never faults. A halfword uses lane addr[1] with addr[0] ignored. A word ignores addr[1:0]. Size and range faults apply in both builds.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load byte 0x13 signed, then the same unsigned: mem_we high one cycle at T+1 of the store. Responses 0xFFFFFFDE, then 0x000000DE, each at T+2.
- After the above, store byte 0x55 to 0x11: READ then WRITE, mem_wdata=0xDEAD55EF, resp_valid at T+3. A subsequent word load of 0x10 returns 0xDEAD55EF.
- Store half 0x8001 to 0x12, then load half 0x12 signed: response 0xFFFF8001. Load unsigned: 0x00008001. Low half unchanged.
- Word load from 0x06 with LSU_MISALIGN_TRAP_EN: resp_fault=1 at T+1, no mem_we. Without the macro: returns word at 0x04.
- Load from 0x100 with DEPTH_WORDS=64, and any request with size=11: resp_fault=1, resp_rdata=0, mem_we never asserted.
- Assert reset during READ of a sub-word store: no mem_we, no resp_valid, req_ready=1 the cycle after reset deasserts.
